fp_mult_result_queue: RTL and testbench

- Downstream stage of the combinational single-precision multiplier.
- Registers each product word z[31:0] with its status byte into a small FIFO, using valid/ready handshakes on both sides.
- Keeps IEEE-style sticky exception flags: the OR of all accepted status bytes, cleared by software.
- Keeps saturating event counters for NaN and for overflow ("huge") results.
- Decouples the multiplier's combinational path from the consumer (writeback/bus).

---
 rtl/fp_mult_result_queue.sv | 106 ++++++++++
 tb/tb_fp_mult_result_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_result_queue.sv
// Result queue behind the combinational single-precision multiplier.
// Buffers {product, status} pairs in a small circular FIFO with valid/ready
// on both sides, and keeps sticky exception flags plus saturating NaN and
// overflow event counters for software.
module fp_mult_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_z,
  input  logic [7:0]               in_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_z,
  output logic [7:0]               out_status,
  output logic [7:0]               sticky_flags,
  input  logic                     flags_clr,
  output logic [CNT_W-1:0]         nan_cnt,
  output logic [CNT_W-1:0]         huge_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic en);
    if (en && (cnt != {CNT_W{1'b1}}))
      sat_inc = cnt + CNT_ONE;
    else
      sat_inc = cnt;
  endfunction

  logic [AW:0]  rd_ptr;
  logic [AW:0]  wr_ptr;
  logic [31:0]  mem_z  [DEPTH];
  logic [7:0]   mem_st [DEPTH];
  logic         full;
  logic         push;
  logic         pop;
  logic [7:0]   st_m;

  // Bits [7:6] are reserved by the multiplier and never stored or accumulated.
  assign st_m = in_status & 8'h3F;

  // Same slot index with opposite wrap bits means the writer lapped the reader.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = !full;
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is gated by out_valid so the data outputs read zero whenever the
  // queue is empty, including straight out of reset.
  assign out_z      = out_valid ? mem_z[rd_ptr[AW-1:0]]  : 32'h0;
  assign out_status = out_valid ? mem_st[rd_ptr[AW-1:0]] : 8'h0;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr[AW-1:0]]  <= in_z;
      mem_st[wr_ptr[AW-1:0]] <= st_m;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky flags and event counters; a clear wins but still keeps the
  // contribution of a push landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
      nan_cnt      <= '0;
      huge_cnt     <= '0;
    end else if (flags_clr) begin
      sticky_flags <= push ? st_m : 8'h0;
      nan_cnt      <= push ? {{(CNT_W-1){1'b0}}, st_m[2]} : '0;
      huge_cnt     <= push ? {{(CNT_W-1){1'b0}}, st_m[4]} : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | st_m;
      nan_cnt      <= sat_inc(nan_cnt, st_m[2]);
      huge_cnt     <= sat_inc(huge_cnt, st_m[4]);
    end
  end

endmodule

// File: tb/tb_fp_mult_result_queue.sv
// Bench for fp_mult_result_queue: directed scenarios with literal
// expectations followed by random traffic, all checked every cycle against
// a queue-based behavioural model.
module tb_fp_mult_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_z = '0;
  logic [7:0]       in_status = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_z;
  logic [7:0]       out_status;
  logic [7:0]       sticky_flags;
  logic             flags_clr = 1'b0;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] huge_cnt;
  logic [$clog2(DEPTH):0] level;

  fp_mult_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_status(in_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr),
    .nan_cnt(nan_cnt), .huge_cnt(huge_cnt), .level(level)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] z;
    logic [7:0]  st;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] m_sticky = 8'h0;
  int         m_nan = 0;
  int         m_huge = 0;
  bit         m_push, m_pop;
  ent_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky = 8'h0;
      m_nan = 0;
      m_huge = 0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() > 0);
      m_e.z  = in_z;
      m_e.st = in_status & 8'h3F;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_e);
      if (flags_clr) begin
        m_sticky = m_push ? m_e.st : 8'h0;
        m_nan    = (m_push && m_e.st[2]) ? 1 : 0;
        m_huge   = (m_push && m_e.st[4]) ? 1 : 0;
      end else if (m_push) begin
        m_sticky = m_sticky | m_e.st;
        if (m_e.st[2] && m_nan < CMAX) m_nan++;
        if (m_e.st[4] && m_huge < CMAX) m_huge++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      cmp("m_out_z", out_z, (mq.size() != 0) ? mq[0].z : 32'h0);
      cmp("m_out_status", {24'b0, out_status}, (mq.size() != 0) ? {24'b0, mq[0].st} : 32'h0);
      cmp("m_level", 32'(level), 32'(mq.size()));
      cmp("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
      cmp("m_sticky", {24'b0, sticky_flags}, {24'b0, m_sticky});
      cmp("m_nan_cnt", 32'(nan_cnt), 32'(m_nan));
      cmp("m_huge_cnt", 32'(huge_cnt), 32'(m_huge));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] words [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [7:0]  accs  [3] = '{8'h20, 8'h14, 8'h01};

  initial begin
    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    cmp("rst_level", 32'(level), 0);
    cmp("rst_out_valid", {31'b0, out_valid}, 0);
    cmp("rst_in_ready", {31'b0, in_ready}, 1);
    tick();

    // Single push, 1-cycle latency
    in_valid = 1'b1; in_z = 32'h40C00000; in_status = 8'h00;
    #1 cmp("push_cycle_out_valid", {31'b0, out_valid}, 0);
    tick();
    in_valid = 1'b0;
    cmp("single_out_valid", {31'b0, out_valid}, 1);
    cmp("single_out_z", out_z, 32'h40C00000);
    cmp("single_level", 32'(level), 1);
    cmp("single_sticky", {24'b0, sticky_flags}, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill to full, refused 5th push, ordered drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_z = words[i];
      tick();
    end
    in_z = 32'hDEADBEEF;
    cmp("full_in_ready", {31'b0, in_ready}, 0);
    cmp("full_level", 32'(level), 4);
    tick();
    in_valid = 1'b0;
    cmp("full_refused_level", 32'(level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("drain_out_z", out_z, words[i]);
      tick();
    end
    cmp("drain_empty", {31'b0, out_valid}, 0);
    out_ready = 1'b0;

    // Streaming push+pop
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_z = 32'h41000000 + i;
      tick();
      cmp("stream_out_z", out_z, 32'h41000000 + i);
      cmp("stream_level", 32'(level), 1);
    end
    in_valid = 1'b0;
    tick();
    cmp("stream_drained", {31'b0, out_valid}, 0);

    // Sticky accumulation and clear-with-push
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_z = 32'h3F800000; in_status = accs[i];
      tick();
    end
    in_valid = 1'b0;
    cmp("acc_sticky", {24'b0, sticky_flags}, 32'h35);
    cmp("acc_nan", 32'(nan_cnt), 1);
    cmp("acc_huge", 32'(huge_cnt), 1);
    flags_clr = 1'b1; in_valid = 1'b1; in_status = 8'h04;
    tick();
    flags_clr = 1'b0; in_valid = 1'b0;
    cmp("clr_sticky", {24'b0, sticky_flags}, 32'h04);
    cmp("clr_nan", 32'(nan_cnt), 1);
    cmp("clr_huge", 32'(huge_cnt), 0);

    // Saturation and reserved-bit masking
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_status = 8'h04;
      tick();
    end
    cmp("sat_nan", 32'(nan_cnt), 3);
    in_status = 8'hC0; in_z = 32'h7FC00000;
    tick();
    in_valid = 1'b0;
    cmp("mask_sticky", {24'b0, sticky_flags}, 32'h04);
    cmp("mask_out_status", {24'b0, out_status}, 0);
    cmp("mask_out_z", out_z, 32'h7FC00000);
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-operation
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_z = 32'h40000000 + i; in_status = (i < 2) ? 8'h04 : 8'h00;
      tick();
    end
    in_valid = 1'b0;
    cmp("pre_rst_level", 32'(level), 3);
    cmp("pre_rst_nan", 32'(nan_cnt), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_out_valid", {31'b0, out_valid}, 0);
    cmp("arst_out_z", out_z, 0);
    cmp("arst_out_status", {24'b0, out_status}, 0);
    cmp("arst_level", 32'(level), 0);
    cmp("arst_sticky", {24'b0, sticky_flags}, 0);
    cmp("arst_nan", 32'(nan_cnt), 0);
    cmp("arst_huge", 32'(huge_cnt), 0);
    tick();
    rst_n = 1'b1;
    #1;
    cmp("post_rst_out_valid", {31'b0, out_valid}, 0);
    cmp("post_rst_in_ready", {31'b0, in_ready}, 1);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_z      = $urandom;
      in_status = 8'($urandom);
      flags_clr = ($urandom_range(0, 24) == 0);
      tick();
    end
    in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    cmp("final_empty", {31'b0, out_valid}, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
